// File: rtl/sfr_probe.sv
// Boot-time SFR probe: reads VERSION/FEAT1/FEAT2 from a slave register file
// and reports whether the slave meets a minimum version and required feature set.
module sfr_probe #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned RD_LAT    = 0,
   parameter logic [23:0] MIN_VER   = 24'h000000,
   parameter logic [31:0] REQ_FEAT1 = 32'h0000_0002
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [3:0]       sfr_addr,
   output logic             sfr_cen,
   output logic [WIDTH-1:0] sfr_din,
   input  logic [WIDTH-1:0] sfr_rdata,
   output logic             busy,
   output logic             done,
   output logic             ok,
   output logic [WIDTH-1:0] version,
   output logic [WIDTH-1:0] feat1,
   output logic [WIDTH-1:0] feat2
);

   localparam int unsigned EW       = (WIDTH > 32) ? WIDTH : 32;
   localparam logic [3:0]  ADDR_VER = 4'h1;
   localparam logic [3:0]  ADDR_F1  = 4'h2;
   localparam logic [3:0]  ADDR_F2  = 4'h3;
   localparam logic [3:0]  LAST_CNT = 4'(RD_LAT);

   typedef enum logic [2:0] {
      IDLE,
      RD_VER,
      RD_F1,
      RD_F2,
      DONE
   } state_t;

   state_t     state;
   logic [3:0] wait_cnt;
   logic       rd_last;
   logic       compat;

   assign sfr_din = '0;

   // Final cycle of a read state: the slave data is valid and gets captured.
   assign rd_last = (wait_cnt == LAST_CNT);

   // Compatibility rule; VERSION and FEAT1 are already held when RD_F2 ends.
   assign compat = (version != '0) &&
                   (24'(version) >= MIN_VER) &&
                   ((EW'(feat1) & EW'(REQ_FEAT1)) == EW'(REQ_FEAT1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
         sfr_addr <= 4'd0;
         sfr_cen  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         ok       <= 1'b0;
         version  <= '0;
         feat1    <= '0;
         feat2    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= RD_VER;
                  wait_cnt <= 4'd0;
                  sfr_addr <= ADDR_VER;
                  sfr_cen  <= 1'b1;
                  busy     <= 1'b1;
                  ok       <= 1'b0;
               end
            end
            RD_VER: begin
               if (rd_last) begin
                  version  <= sfr_rdata;
                  state    <= RD_F1;
                  wait_cnt <= 4'd0;
                  sfr_addr <= ADDR_F1;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            RD_F1: begin
               if (rd_last) begin
                  feat1    <= sfr_rdata;
                  state    <= RD_F2;
                  wait_cnt <= 4'd0;
                  sfr_addr <= ADDR_F2;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            RD_F2: begin
               if (rd_last) begin
                  feat2    <= sfr_rdata;
                  state    <= DONE;
                  wait_cnt <= 4'd0;
                  sfr_addr <= 4'd0;
                  sfr_cen  <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  ok       <= compat;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state    <= IDLE;
               wait_cnt <= 4'd0;
               sfr_addr <= 4'd0;
               sfr_cen  <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sfr_probe.sv
// Bench for sfr_probe: two instances (RD_LAT=0 and RD_LAT=2 with a raised
// MIN_VER) share one SFR image and are checked against a timeline model.
module tb_sfr_probe;

   localparam int unsigned W = 32;

   typedef struct {
      logic [31:0] ver;
      logic [31:0] f1;
      logic [31:0] f2;
      logic        ok0;
      logic        ok1;
   } vec_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [31:0]  mem [0:15];
   logic [31:0]  junk;

   logic [3:0]   addr0, addr1;
   logic         cen0, cen1, busy0, busy1, done0, done1, ok0, ok1;
   logic [W-1:0] din0, din1, rdata0, rdata1;
   logic [W-1:0] ver0, ver1, f10, f11, f20, f21;

   int checks = 0;
   int failures = 0;
   int ndone0, ndone1;

   // Reference model: cycles elapsed since the accepted start
   bit          act [2];
   int          t   [2];
   logic [31:0] mver [2];
   logic [31:0] mf1  [2];
   logic [31:0] mf2  [2];
   bit          mok  [2];

   always #5 clk = ~clk;

   // Slave returns garbage whenever it is not enabled
   assign rdata0 = cen0 ? mem[addr0] : junk;
   assign rdata1 = cen1 ? mem[addr1] : junk;

   sfr_probe #(.WIDTH(W), .RD_LAT(0), .MIN_VER(24'h000000), .REQ_FEAT1(32'h2)) dut0 (
      .clk(clk), .reset(reset), .start(start), .sfr_addr(addr0), .sfr_cen(cen0),
      .sfr_din(din0), .sfr_rdata(rdata0), .busy(busy0), .done(done0), .ok(ok0),
      .version(ver0), .feat1(f10), .feat2(f20));

   sfr_probe #(.WIDTH(W), .RD_LAT(2), .MIN_VER(24'h010300), .REQ_FEAT1(32'h2)) dut1 (
      .clk(clk), .reset(reset), .start(start), .sfr_addr(addr1), .sfr_cen(cen1),
      .sfr_din(din1), .sfr_rdata(rdata1), .busy(busy1), .done(done1), .ok(ok1),
      .version(ver1), .feat1(f11), .feat2(f21));

   task automatic check(input string name, input logic [167:0] got, input logic [167:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_step(input int d, input int lat, input logic [23:0] minv);
      int n;
      n = 3 * (lat + 1);
      if (reset) begin
         act[d] = 0; t[d] = 0; mver[d] = 0; mf1[d] = 0; mf2[d] = 0; mok[d] = 0;
      end else if (!act[d]) begin
         if (start) begin
            act[d] = 1; t[d] = 1; mok[d] = 0;
         end
      end else begin
         if (t[d] <= n && (t[d] % (lat + 1)) == 0) begin
            case (t[d] / (lat + 1))
               1: mver[d] = mem[1];
               2: mf1[d]  = mem[2];
               default: mf2[d] = mem[3];
            endcase
         end
         if (t[d] == n)
            mok[d] = (mver[d] != 0) && (mver[d][23:0] >= minv) && ((mf1[d] & 32'h2) == 32'h2);
         if (t[d] == n + 1) begin
            act[d] = 0; t[d] = 0;
         end else begin
            t[d]++;
         end
      end
   endtask

   function automatic logic [167:0] model_out(input int d, input int lat);
      logic       c;
      logic [3:0] a;
      logic       dn;
      int         n;
      n  = 3 * (lat + 1);
      c  = act[d] && t[d] <= n;
      a  = c ? 4'(1 + (t[d] - 1) / (lat + 1)) : 4'd0;
      dn = act[d] && t[d] == n + 1;
      return {a, c, c, dn, mok[d], mver[d], mf1[d], mf2[d], 32'h0};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step(0, 0, 24'h000000);
      model_step(1, 2, 24'h010300);
      @(negedge clk);
      check("cycle_lat0", {addr0, cen0, busy0, done0, ok0, ver0, f10, f20, din0}, model_out(0, 0));
      check("cycle_lat2", {addr1, cen1, busy1, done1, ok1, ver1, f11, f21, din1}, model_out(1, 2));
      if (done0) ndone0++;
      if (done1) ndone1++;
      junk = $urandom;
   endtask

   vec_t tbl [5];

   task automatic run_vec(input int i);
      int d0, d1;
      mem[1] = tbl[i].ver; mem[2] = tbl[i].f1; mem[3] = tbl[i].f2;
      d0 = -1; d1 = -1;
      for (int j = 1; j <= 12; j++) begin
         start = (j == 1);
         tick();
         if (done0 && d0 < 0) d0 = j;
         if (done1 && d1 < 0) d1 = j;
      end
      start = 1'b0;
      check($sformatf("v%0d_done_cyc0", i), 168'(d0), 168'(4));
      check($sformatf("v%0d_done_cyc2", i), 168'(d1), 168'(10));
      check($sformatf("v%0d_ok0", i), 168'(ok0), 168'(tbl[i].ok0));
      check($sformatf("v%0d_ok2", i), 168'(ok1), 168'(tbl[i].ok1));
      check($sformatf("v%0d_regs0", i), {ver0, f10, f20}, {tbl[i].ver, tbl[i].f1, tbl[i].f2});
      check($sformatf("v%0d_regs2", i), {ver1, f11, f21}, {tbl[i].ver, tbl[i].f1, tbl[i].f2});
   endtask

   function automatic logic [31:0] pick_ver();
      case ($urandom_range(0, 3))
         0: return 32'h0;
         1: return 32'h0001_0203;
         2: return 32'h0001_0300;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      tbl[0] = '{32'h0001_0203, 32'h0000_000F, 32'h0,         1'b1, 1'b0};
      tbl[1] = '{32'h0001_0203, 32'h0000_0001, 32'h0,         1'b0, 1'b0};
      tbl[2] = '{32'h0000_0000, 32'h0000_000F, 32'h5,         1'b0, 1'b0};
      tbl[3] = '{32'h0001_0300, 32'h0000_0002, 32'h0000_ABCD, 1'b1, 1'b1};
      tbl[4] = '{32'hFF02_0000, 32'h0000_0003, 32'h1234_5678, 1'b1, 1'b1};
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      junk = $urandom;
      reset = 1'b1;
      start = 1'b0;
      ndone0 = 0; ndone1 = 0;
      repeat (3) tick();
      check("reset_state0", {addr0, cen0, busy0, done0, ok0, ver0, f10, f20, din0}, 168'h0);
      check("reset_state2", {addr1, cen1, busy1, done1, ok1, ver1, f11, f21, din1}, 168'h0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) run_vec(i);

      // Reset during RD_F1 of the fast instance, with start also high
      mem[1] = 32'h0001_0203; mem[2] = 32'hF; mem[3] = 32'h0;
      start = 1'b1; tick();
      start = 1'b0; tick();
      check("in_rd_f1_addr", 168'(addr0), 168'(4'h2));
      reset = 1'b1; start = 1'b1; tick();
      check("abort_outputs0", {addr0, cen0, busy0, done0, ok0, ver0, f10, f20}, 168'h0);
      check("abort_outputs2", {addr1, cen1, busy1, done1, ok1, ver1, f11, f21}, 168'h0);
      reset = 1'b0; start = 1'b0;
      ndone0 = 0; ndone1 = 0;
      repeat (12) tick();
      check("abort_no_done0", 168'(ndone0), 168'(0));
      run_vec(0);

      // Start held high: back-to-back runs, one IDLE cycle between them
      ndone0 = 0; ndone1 = 0;
      start = 1'b1;
      repeat (25) tick();
      check("held_start_dones0", 168'(ndone0), 168'(5));
      check("held_start_dones2", 168'(ndone1), 168'(2));
      start = 1'b0;
      repeat (12) tick();

      // Randomized traffic against the model
      for (int c = 0; c < 800; c++) begin
         reset = ($urandom_range(0, 59) == 0);
         start = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 19) == 0) begin
            mem[1] = pick_ver();
            mem[2] = $urandom_range(0, 1) ? ($urandom | 32'h2) : $urandom;
            mem[3] = $urandom;
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
